farm_sensor_conditioner: RTL and testbench

Conditions the raw farm-road vehicle loop detector and produces the car-waiting request `c` consumed by `traffic_light`. The block synchronizes and debounces the loop, counts queued vehicles (arrivals up, departures down), and tracks how long the oldest waiting vehicle has been starved. `c` is derived from queue depth, starvation time and the current farm-road phase. It sits directly upstream of the controller; `FG` from the controller is fed back as `fg`.

---
 rtl/farm_sensor_conditioner_if.sv | 23 ++
 rtl/farm_sensor_conditioner.sv | 133 +++++++++++++
 tb/tb_farm_sensor_conditioner.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/farm_sensor_conditioner_if.sv
// Signal bundle between the farm-road loop conditioner and its neighbours:
// raw loop, departure pulse and FG feedback in; request, queue depth and status out.
interface farm_sensor_conditioner_if #(
    parameter int CW = 4
);
    logic          loop_in;
    logic          depart;
    logic          fg;
    logic          c;
    logic [CW-1:0] car_count;
    logic          loop_stable;
    logic          wait_timeout;

    modport master (
        output loop_in, depart, fg,
        input  c, car_count, loop_stable, wait_timeout
    );

    modport slave (
        input  loop_in, depart, fg,
        output c, car_count, loop_stable, wait_timeout
    );
endinterface

// File: rtl/farm_sensor_conditioner.sv
// Synchronizes and debounces the farm-road vehicle loop, tracks queue depth and
// starvation time, and produces the registered car-waiting request for traffic_light.
module farm_sensor_conditioner #(
    parameter int DEB     = 4,
    parameter int CW      = 4,
    parameter int THRESH  = 2,
    parameter int WAIT_W  = 8,
    parameter int MAXWAIT = 200
) (
    input  logic                      clk,
    input  logic                      reset,
    farm_sensor_conditioner_if.slave  bus
);
    localparam int DC_W = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [CW-1:0]     CNT_MAX   = {CW{1'b1}};
    localparam logic [DC_W-1:0]   DC_LAST   = DC_W'(DEB - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(MAXWAIT);
    localparam logic [CW-1:0]     THRESH_CW = CW'(THRESH);

    typedef enum logic [1:0] {LOW, RISE_CHK, HIGH, FALL_CHK} state_t;

    logic              s1, s2;
    state_t            state;
    logic [DC_W-1:0]   dc;
    logic              stable;
    logic              arrival;
    logic [CW-1:0]     car_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              req;

    // Two-flop synchronizer; only s2 is ever looked at downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.loop_in;
            s2 <= s1;
        end
    end

    // Arrival is the qualifying RISE_CHK->HIGH transition, so the count moves on the same edge as loop_stable.
    assign arrival = (state == RISE_CHK) && s2 && (dc == DC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= LOW;
            dc     <= '0;
            stable <= 1'b0;
        end else begin
            case (state)
                LOW: begin
                    if (s2) begin
                        state <= RISE_CHK;
                        dc    <= DC_W'(1);
                    end
                end
                RISE_CHK: begin
                    if (!s2) begin
                        state <= LOW;
                        dc    <= '0;
                    end else if (dc == DC_LAST) begin
                        state  <= HIGH;
                        dc     <= '0;
                        stable <= 1'b1;
                    end else begin
                        dc <= dc + DC_W'(1);
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state <= FALL_CHK;
                        dc    <= DC_W'(1);
                    end
                end
                FALL_CHK: begin
                    if (s2) begin
                        state <= HIGH;
                        dc    <= '0;
                    end else if (dc == DC_LAST) begin
                        state  <= LOW;
                        dc     <= '0;
                        stable <= 1'b0;
                    end else begin
                        dc <= dc + DC_W'(1);
                    end
                end
                default: begin
                    state <= LOW;
                    dc    <= '0;
                end
            endcase
        end
    end

    // Simultaneous arrival and departure cancel, even at the empty and full limits.
    always_ff @(posedge clk) begin
        if (reset) begin
            car_cnt <= '0;
        end else if (arrival && !bus.depart) begin
            if (car_cnt != CNT_MAX) car_cnt <= car_cnt + CW'(1);
        end else if (bus.depart && !arrival) begin
            if (car_cnt != '0) car_cnt <= car_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if ((car_cnt == '0) || bus.fg) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LIM) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // While green, hold the request as long as anyone is queued; otherwise ask on depth or starvation.
    always_ff @(posedge clk) begin
        if (reset) begin
            req <= 1'b0;
        end else if (bus.fg) begin
            req <= (car_cnt != '0);
        end else begin
            req <= (car_cnt >= THRESH_CW) || (wait_cnt == WAIT_LIM);
        end
    end

    assign bus.c            = req;
    assign bus.car_count    = car_cnt;
    assign bus.loop_stable  = stable;
    assign bus.wait_timeout = (wait_cnt == WAIT_LIM);

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// Directed bench for farm_sensor_conditioner: reset, debounce, counting,
// starvation timing, request rules, saturation and mid-qualification reset.
module tb_farm_sensor_conditioner;
    logic clk;
    logic reset;
    int   total;
    int   passed;

    farm_sensor_conditioner_if #(.CW(4)) bus ();

    farm_sensor_conditioner #(
        .DEB(4), .CW(4), .THRESH(2), .WAIT_W(8), .MAXWAIT(20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are read on falling edges; step(k) returns just after rising edge k.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.loop_in = 1'b0;
        bus.depart  = 1'b0;
        bus.fg      = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic car(input int hi, input int lo);
        bus.loop_in = 1'b1;
        step(hi);
        bus.loop_in = 1'b0;
        step(lo);
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.loop_in = 1'b1;
        bus.depart  = 1'b0;
        bus.fg      = 1'b0;
        step(2);
        total++; if (bus.c !== 1'b0) $display("FAIL reset_c: got %0b expected 0", bus.c); else passed++;
        total++; if (bus.car_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", bus.car_count); else passed++;
        total++; if (bus.loop_stable !== 1'b0) $display("FAIL reset_stable: got %0b expected 0", bus.loop_stable); else passed++;
        total++; if (bus.wait_timeout !== 1'b0) $display("FAIL reset_timeout: got %0b expected 0", bus.wait_timeout); else passed++;
        reset = 1'b0;
        step(5);
        total++; if (bus.car_count !== 4'd0) $display("FAIL reset_early_arrival: got %0d expected 0", bus.car_count); else passed++;
        step(1);
        total++; if (bus.car_count !== 4'd1) $display("FAIL reset_first_arrival: got %0d expected 1", bus.car_count); else passed++;
    endtask

    task automatic test_single_car();
        do_reset();
        bus.loop_in = 1'b1;
        step(5);
        total++; if (bus.loop_stable !== 1'b0) $display("FAIL single_stable_e5: got %0b expected 0", bus.loop_stable); else passed++;
        step(1);
        total++; if (bus.loop_stable !== 1'b1) $display("FAIL single_stable_e6: got %0b expected 1", bus.loop_stable); else passed++;
        total++; if (bus.car_count !== 4'd1) $display("FAIL single_count_e6: got %0d expected 1", bus.car_count); else passed++;
        total++; if (bus.c !== 1'b0) $display("FAIL single_c_e6: got %0b expected 0", bus.c); else passed++;
        step(4);
        bus.loop_in = 1'b0;
        step(15);
        total++; if (bus.wait_timeout !== 1'b0) $display("FAIL single_timeout_e25: got %0b expected 0", bus.wait_timeout); else passed++;
        total++; if (bus.c !== 1'b0) $display("FAIL single_c_e25: got %0b expected 0", bus.c); else passed++;
        step(1);
        total++; if (bus.wait_timeout !== 1'b1) $display("FAIL single_timeout_e26: got %0b expected 1", bus.wait_timeout); else passed++;
        total++; if (bus.c !== 1'b0) $display("FAIL single_c_e26: got %0b expected 0", bus.c); else passed++;
        step(1);
        total++; if (bus.c !== 1'b1) $display("FAIL single_c_e27: got %0b expected 1", bus.c); else passed++;
    endtask

    task automatic test_glitch();
        do_reset();
        car(3, 10);
        total++; if (bus.car_count !== 4'd0) $display("FAIL glitch_pulse_count: got %0d expected 0", bus.car_count); else passed++;
        total++; if (bus.loop_stable !== 1'b0) $display("FAIL glitch_pulse_stable: got %0b expected 0", bus.loop_stable); else passed++;
        bus.loop_in = 1'b1;
        step(8);
        total++; if (bus.car_count !== 4'd1) $display("FAIL glitch_dip_first: got %0d expected 1", bus.car_count); else passed++;
        bus.loop_in = 1'b0;
        step(3);
        bus.loop_in = 1'b1;
        step(3);
        total++; if (bus.loop_stable !== 1'b1) $display("FAIL glitch_dip_stable: got %0b expected 1", bus.loop_stable); else passed++;
        step(10);
        total++; if (bus.car_count !== 4'd1) $display("FAIL glitch_dip_count: got %0d expected 1", bus.car_count); else passed++;
        bus.loop_in = 1'b0;
        step(8);
        total++; if (bus.loop_stable !== 1'b0) $display("FAIL glitch_release_stable: got %0b expected 0", bus.loop_stable); else passed++;
        total++; if (bus.car_count !== 4'd1) $display("FAIL glitch_release_count: got %0d expected 1", bus.car_count); else passed++;
    endtask

    task automatic test_threshold();
        do_reset();
        car(6, 8);
        bus.loop_in = 1'b1;
        step(5);
        total++; if (bus.car_count !== 4'd1) $display("FAIL thresh_pre: got %0d expected 1", bus.car_count); else passed++;
        step(1);
        total++; if (bus.car_count !== 4'd2) $display("FAIL thresh_count_e: got %0d expected 2", bus.car_count); else passed++;
        total++; if (bus.c !== 1'b0) $display("FAIL thresh_c_e: got %0b expected 0", bus.c); else passed++;
        step(1);
        total++; if (bus.c !== 1'b1) $display("FAIL thresh_c_e1: got %0b expected 1", bus.c); else passed++;
        total++; if (bus.wait_timeout !== 1'b0) $display("FAIL thresh_timeout: got %0b expected 0", bus.wait_timeout); else passed++;
        bus.loop_in = 1'b0;
    endtask

    task automatic test_drain();
        bus.fg = 1'b1;
        step(1);
        total++; if (bus.c !== 1'b1) $display("FAIL drain_c_green: got %0b expected 1", bus.c); else passed++;
        total++; if (bus.wait_timeout !== 1'b0) $display("FAIL drain_timeout_green: got %0b expected 0", bus.wait_timeout); else passed++;
        step(6);
        bus.depart = 1'b1;
        step(1);
        bus.depart = 1'b0;
        total++; if (bus.car_count !== 4'd1) $display("FAIL drain_first: got %0d expected 1", bus.car_count); else passed++;
        step(1);
        total++; if (bus.c !== 1'b1) $display("FAIL drain_c_one: got %0b expected 1", bus.c); else passed++;
        bus.depart = 1'b1;
        step(1);
        bus.depart = 1'b0;
        total++; if (bus.car_count !== 4'd0) $display("FAIL drain_second: got %0d expected 0", bus.car_count); else passed++;
        total++; if (bus.c !== 1'b1) $display("FAIL drain_c_lag: got %0b expected 1", bus.c); else passed++;
        step(1);
        total++; if (bus.c !== 1'b0) $display("FAIL drain_c_drop: got %0b expected 0", bus.c); else passed++;
        bus.depart = 1'b1;
        step(1);
        bus.depart = 1'b0;
        total++; if (bus.car_count !== 4'd0) $display("FAIL drain_empty_depart: got %0d expected 0", bus.car_count); else passed++;
        bus.loop_in = 1'b1;
        step(5);
        bus.depart = 1'b1;
        step(1);
        bus.depart = 1'b0;
        total++; if (bus.car_count !== 4'd0) $display("FAIL drain_coincide_zero: got %0d expected 0", bus.car_count); else passed++;
        total++; if (bus.loop_stable !== 1'b1) $display("FAIL drain_coincide_stable: got %0b expected 1", bus.loop_stable); else passed++;
        bus.loop_in = 1'b0;
        step(8);
        car(6, 8);
        total++; if (bus.car_count !== 4'd1) $display("FAIL drain_refill: got %0d expected 1", bus.car_count); else passed++;
        bus.loop_in = 1'b1;
        step(5);
        bus.depart = 1'b1;
        step(1);
        bus.depart = 1'b0;
        total++; if (bus.car_count !== 4'd1) $display("FAIL drain_coincide_one: got %0d expected 1", bus.car_count); else passed++;
        step(1);
        total++; if (bus.c !== 1'b1) $display("FAIL drain_c_after: got %0b expected 1", bus.c); else passed++;
        bus.loop_in = 1'b0;
        bus.fg      = 1'b0;
    endtask

    task automatic test_saturation_reset();
        do_reset();
        bus.fg = 1'b1;
        for (int i = 0; i < 15; i++) car(6, 6);
        total++; if (bus.car_count !== 4'd15) $display("FAIL sat_fifteen: got %0d expected 15", bus.car_count); else passed++;
        car(6, 6);
        total++; if (bus.car_count !== 4'd15) $display("FAIL sat_hold: got %0d expected 15", bus.car_count); else passed++;
        bus.fg      = 1'b0;
        bus.loop_in = 1'b1;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        total++; if (bus.car_count !== 4'd0) $display("FAIL midreset_count: got %0d expected 0", bus.car_count); else passed++;
        total++; if (bus.loop_stable !== 1'b0) $display("FAIL midreset_stable: got %0b expected 0", bus.loop_stable); else passed++;
        step(5);
        total++; if (bus.car_count !== 4'd0) $display("FAIL midreset_no_early: got %0d expected 0", bus.car_count); else passed++;
        step(1);
        total++; if (bus.car_count !== 4'd1) $display("FAIL midreset_requal: got %0d expected 1", bus.car_count); else passed++;
        bus.loop_in = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_single_car();
        test_glitch();
        test_threshold();
        test_drain();
        test_saturation_reset();
        step(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
